// File: rtl/snn_timestep_scheduler.sv
// Timestep sequencer for the SNN core: per output neuron it leaks the stored
// membrane potential, scans the input spike bitmap while integrating matching
// weights, resolves firing and hands spike events to the spike queue.
module snn_timestep_scheduler #(
  parameter int N_IN  = 196,
  parameter int N_OUT = 10,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clear,
  output logic          busy,
  output logic          done,
  output logic [7:0]    in_addr,
  input  logic          in_bit,
  output logic          w_rd,
  output logic [AW-1:0] w_addr,
  input  logic [7:0]    w_data,
  output logic          nrn_func,
  output logic [7:0]    nrn_weight,
  output logic [7:0]    nrn_vmem,
  input  logic [7:0]    nrn_result,
  input  logic          nrn_spike,
  output logic          spk_valid,
  output logic [3:0]    spk_id,
  input  logic          spk_ready,
  input  logic [3:0]    dbg_id,
  output logic [7:0]    dbg_vmem
);

  typedef enum logic [2:0] {
    IDLE, LEAK, SCAN, DRAIN, FIRE, EMIT, DONE
  } state_t;

  localparam logic [7:0] I_LAST = 8'(N_IN - 1);
  localparam logic [3:0] J_LAST = 4'(N_OUT - 1);

  state_t     state;
  logic [7:0] vmem [N_OUT];
  logic [7:0] acc;
  logic [7:0] i;
  logic [3:0] j;
  logic       consume;

  // A bitmap/weight pair issued last cycle is integrated only when its bit is set;
  // in SCAN the first cycle (i==0) has nothing outstanding yet.
  assign consume = (((state == SCAN) && (i != '0)) || (state == DRAIN)) && in_bit;

  // Membrane potential debug read port.
  assign dbg_vmem = (int'(dbg_id) < N_OUT) ? vmem[dbg_id] : '0;

  // Neuron operands are combinational so the neuron result can be captured in the same cycle.
  always_comb begin
    nrn_func   = 1'b0;
    nrn_weight = '0;
    nrn_vmem   = '0;
    case (state)
      LEAK: begin
        nrn_func = 1'b1;
        nrn_vmem = vmem[j];
      end
      SCAN, DRAIN: begin
        if (consume) begin
          nrn_vmem   = acc;
          nrn_weight = w_data;
        end
      end
      FIRE: begin
        nrn_vmem = acc;
      end
      default: ;
    endcase
  end

  // Sequencer FSM; control outputs are registered to match the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      for (int unsigned k = 0; k < N_OUT; k++) vmem[k] <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_addr   <= '0;
      w_addr    <= '0;
      w_rd      <= 1'b0;
      spk_valid <= 1'b0;
      spk_id    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            j     <= '0;
            busy  <= 1'b1;
            state <= LEAK;
          end else if (clear) begin
            for (int unsigned k = 0; k < N_OUT; k++) vmem[k] <= '0;
          end
        end
        LEAK: begin
          acc     <= nrn_result;
          i       <= '0;
          in_addr <= '0;
          w_addr  <= AW'(int'(j) * N_IN);
          w_rd    <= 1'b1;
          state   <= SCAN;
        end
        SCAN: begin
          if (consume) acc <= nrn_result;
          i <= i + 8'd1;
          if (i == I_LAST) begin
            w_rd    <= 1'b0;
            in_addr <= '0;
            w_addr  <= '0;
            state   <= DRAIN;
          end else begin
            in_addr <= i + 8'd1;
            w_addr  <= w_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (consume) acc <= nrn_result;
          state <= FIRE;
        end
        FIRE: begin
          if (nrn_spike) begin
            vmem[j]   <= '0;
            spk_valid <= 1'b1;
            spk_id    <= j;
            state     <= EMIT;
          end else begin
            vmem[j] <= acc;
            if (j == J_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              j     <= j + 4'd1;
              state <= LEAK;
            end
          end
        end
        EMIT: begin
          if (spk_ready) begin
            spk_valid <= 1'b0;
            spk_id    <= '0;
            if (j == J_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              j     <= j + 4'd1;
              state <= LEAK;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Self-checking bench for snn_timestep_scheduler with a stub neuron, bitmap and
// weight memory, checked against a per-timestep arithmetic model.
module tb_snn_timestep_scheduler;

  localparam int N_IN  = 196;
  localparam int N_OUT = 10;
  localparam int AW    = 11;
  localparam int LIMIT = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          busy, done;
  logic [7:0]    in_addr;
  logic          in_bit = 1'b0;
  logic          w_rd;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_data = '0;
  logic          nrn_func;
  logic [7:0]    nrn_weight, nrn_vmem;
  logic [7:0]    nrn_result;
  logic          nrn_spike;
  logic          spk_valid;
  logic [3:0]    spk_id;
  logic          spk_ready = 1'b1;
  logic [3:0]    dbg_id = '0;
  logic [7:0]    dbg_vmem;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] w_mem [0:2047];
  bit         bits  [0:255];
  int         vm    [N_OUT];
  int         exp_q [$];
  logic [8:0] nsum;

  always #5 clk = ~clk;

  snn_timestep_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .busy(busy), .done(done), .in_addr(in_addr), .in_bit(in_bit),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .nrn_func(nrn_func), .nrn_weight(nrn_weight), .nrn_vmem(nrn_vmem),
    .nrn_result(nrn_result), .nrn_spike(nrn_spike),
    .spk_valid(spk_valid), .spk_id(spk_id), .spk_ready(spk_ready),
    .dbg_id(dbg_id), .dbg_vmem(dbg_vmem)
  );

  // One-cycle-latency bitmap and weight SRAM.
  always @(posedge clk) begin
    in_bit <= bits[in_addr];
    if (w_rd) w_data <= w_mem[w_addr];
  end

  // Stub neuron: saturating integrate, leak v - v/4, spike at 100 or more.
  always_comb begin
    nsum = {1'b0, nrn_vmem} + {1'b0, nrn_weight};
    if (nrn_func) nrn_result = nrn_vmem - (nrn_vmem >> 2);
    else          nrn_result = nsum[8] ? 8'hFF : nsum[7:0];
    nrn_spike = (nrn_result >= 8'd100);
  end

  // Reference timestep: returns number of firing neurons, fills exp_q with their ids.
  function automatic int model_ts();
    int nf = 0;
    exp_q.delete();
    for (int jj = 0; jj < N_OUT; jj++) begin
      int v = vm[jj] - vm[jj] / 4;
      for (int ii = 0; ii < N_IN; ii++)
        if (bits[ii]) begin
          v += int'(w_mem[jj * N_IN + ii]);
          if (v > 255) v = 255;
        end
      if (v >= 100) begin
        vm[jj] = 0;
        exp_q.push_back(jj);
        nf++;
      end else vm[jj] = v;
    end
    return nf;
  endfunction

  task automatic check_vmem(input string tag);
    for (int k = 0; k < N_OUT; k++) begin
      dbg_id = 4'(k);
      #1;
      vectors++;
      if (dbg_vmem !== 8'(vm[k])) begin
        miscompares++;
        $display("FAIL %s vmem[%0d]: got %0d, expected %0d", tag, k, dbg_vmem, vm[k]);
      end
    end
  endtask

  task automatic run_ts(input string tag, input int stall_first, input bit rnd_ready,
                        input bit with_clear, output int lat);
    int nf, stalls, stall_cnt, exp_lat;
    bit prev_hold;
    logic [3:0] prev_id;
    int got [$];
    nf = model_ts();
    stalls = 0; stall_cnt = 0; prev_hold = 0; prev_id = '0;
    start = 1'b1; clear = with_clear; spk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_rise: got %b, expected 1", tag, busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (prev_hold) begin
        vectors++;
        if (spk_valid !== 1'b1 || spk_id !== prev_id) begin
          miscompares++;
          $display("FAIL %s spk_hold: got valid=%b id=%0d, expected valid=1 id=%0d",
                   tag, spk_valid, spk_id, prev_id);
        end
      end
      prev_hold = 0;
      if (spk_valid === 1'b1) begin
        if (got.size() == 0 && stall_cnt < stall_first) begin
          spk_ready = 1'b0;
          stall_cnt++;
        end else if (rnd_ready) spk_ready = ($urandom_range(0, 2) != 0);
        else spk_ready = 1'b1;
        if (spk_ready) got.push_back(int'(spk_id));
        else begin
          stalls++;
          prev_hold = 1;
          prev_id = spk_id;
        end
      end else begin
        spk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    spk_ready = 1'b1;
    exp_lat = N_OUT * (N_IN + 3) + nf + stalls;
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s done_latency: got %0d, expected %0d", tag, lat, exp_lat);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_fall: got busy=%b done=%b, expected 0 0", tag, busy, done);
    end
    vectors++;
    if (got.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s spike_count: got %0d, expected %0d", tag, got.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if (got[k] != exp_q[k]) begin
          miscompares++;
          $display("FAIL %s spike_id[%0d]: got %0d, expected %0d", tag, k, got[k], exp_q[k]);
        end
      end
    end
    check_vmem(tag);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s clear_busy: got %b, expected 0", tag, busy);
    end
    for (int k = 0; k < N_OUT; k++) vm[k] = 0;
    check_vmem(tag);
  endtask

  task automatic set_bits(input int lo, input int hi);
    for (int k = 0; k < 256; k++) bits[k] = (k >= lo && k <= hi);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2048; k++) w_mem[k] = '0;
    for (int k = 0; k < 256; k++) bits[k] = 1'b0;
    for (int k = 0; k < N_OUT; k++) vm[k] = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, w_rd, spk_valid, spk_id, in_addr, w_addr, nrn_func, nrn_weight, nrn_vmem} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b w_rd=%b spk_valid=%b spk_id=%0d in_addr=%0d w_addr=%0d nrn=%b/%0d/%0d, expected all 0",
               busy, done, w_rd, spk_valid, spk_id, in_addr, w_addr, nrn_func, nrn_weight, nrn_vmem);
    end
    check_vmem("reset");
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_cycle%0d: got busy=%b done=%b, expected 0 0", c, busy, done);
      end
    end
  endtask

  task automatic test_no_fire();
    int lat;
    for (int k = 0; k < 2048; k++) w_mem[k] = 8'd10;
    for (int k = 0; k < 256; k++) bits[k] = (k == 5 || k == 7);
    run_ts("no_fire", 0, 0, 0, lat);
    vectors++;
    if (lat != 1990) begin
      miscompares++;
      $display("FAIL no_fire latency_const: got %0d, expected 1990", lat);
    end
  endtask

  task automatic test_all_fire(output int lat);
    set_bits(0, 11);
    run_ts("all_fire", 0, 0, 0, lat);
  endtask

  task automatic test_back_pressure(input int base_lat);
    int lat;
    run_ts("back_pressure", 5, 0, 0, lat);
    vectors++;
    if (lat != base_lat + 5) begin
      miscompares++;
      $display("FAIL back_pressure delay: got %0d, expected %0d", lat, base_lat + 5);
    end
  endtask

  task automatic test_two_timesteps();
    int lat;
    do_clear("pre_clear");
    for (int k = 0; k < 2048; k++) w_mem[k] = '0;
    for (int k = 0; k < N_OUT; k++) w_mem[k * N_IN + 3] = 8'd40;
    set_bits(3, 3);
    run_ts("ts1", 0, 0, 0, lat);
    dbg_id = 4'd2; #1;
    vectors++;
    if (dbg_vmem !== 8'd40) begin
      miscompares++;
      $display("FAIL ts1 vmem_const: got %0d, expected 40", dbg_vmem);
    end
    run_ts("ts2", 0, 0, 0, lat);
    dbg_id = 4'd7; #1;
    vectors++;
    if (dbg_vmem !== 8'd70) begin
      miscompares++;
      $display("FAIL ts2 vmem_const: got %0d, expected 70", dbg_vmem);
    end
    run_ts("start_clear", 0, 0, 1, lat);
    do_clear("clear");
  endtask

  task automatic test_random();
    int lat;
    int wmax [3] = '{3, 8, 20};
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 2048; k++) w_mem[k] = 8'($urandom_range(0, wmax[r]));
      for (int k = 0; k < 256; k++) bits[k] = ($urandom_range(0, 7) == 0);
      run_ts($sformatf("random%0d", r), 0, 1, 0, lat);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int lat;
    spk_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(w_rd === 1'b1 && int'(w_addr) >= 4 * N_IN + 10) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc >= LIMIT) begin
      miscompares++;
      $display("FAIL reset_mid reach_neuron4: got %0d cycles, expected < %0d", cyc, LIMIT);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || w_rd !== 1'b0 || spk_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid outputs: got busy=%b w_rd=%b spk_valid=%b done=%b, expected 0 0 0 0",
               busy, w_rd, spk_valid, done);
    end
    for (int k = 0; k < N_OUT; k++) vm[k] = 0;
    check_vmem("reset_mid");
    rst_n = 1'b1;
    @(negedge clk);
    run_ts("after_reset", 0, 0, 0, lat);
  endtask

  initial begin
    int base_lat;
    test_reset();
    test_no_fire();
    test_all_fire(base_lat);
    test_back_pressure(base_lat);
    test_two_timesteps();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snn_timestep_scheduler.md
# snn_timestep_scheduler

Sequencer that runs one SNN timestep across all output neurons. For each neuron it leaks the stored membrane potential, then scans the input spike bitmap. For every active input it fetches the matching weight from the weight SRAM read port and integrates it through the neuron datapath. It then resolves firing and emits output spike events to the spike queue. It sits between the Wishbone/LA control registers and the weight SRAM, neuron and spike-queue instances, and owns the membrane-potential state.

## Interface
- N_IN, 196: input neurons (14*14), indices 0..N_IN-1
- N_OUT, 10: output neurons
- AW, 11: weight address width; weight for (out j, in i) at j*N_IN+i
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run one timestep; sampled only in IDLE
- clear  in  1  zero all vmem; sampled only in IDLE, ignored if start also high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at timestep completion
- in_addr  out  8  input spike bitmap index
- in_bit  in  1  bitmap bit for in_addr issued previous cycle
- w_rd  out  1  weight read strobe (drives csb1 low)
- w_addr  out  AW  weight read address
- w_data  in  8  weight, valid cycle after w_rd
- nrn_func  out  1  0 = integrate, 1 = leak
- nrn_weight  out  8  neuron weight operand
- nrn_vmem  out  8  neuron vmem operand
- nrn_result  in  8  neuron v_mem_out, combinational from operands
- nrn_spike  in  1  neuron spike, combinational from operands
- spk_valid  out  1  output spike event valid
- spk_id  out  4  firing output neuron index
- spk_ready  in  1  queue accepts event
- dbg_id  in  4  vmem debug read index
- dbg_vmem  out  8  vmem[dbg_id], combinational

## Operation
- State: vmem[0..N_OUT-1] (8 bit each), acc (8 bit), j (output counter), i (input counter).
- FSM states: IDLE, LEAK, SCAN, DRAIN, FIRE, EMIT, DONE.
- IDLE: if start, set j=0 and go to LEAK. Else if clear, zero all vmem in one cycle and stay in IDLE.
- LEAK (1 cycle): nrn_func=1, nrn_vmem=vmem[j], nrn_weight=0. Capture acc<=nrn_result. Set i=0. Go to SCAN.
- SCAN (N_IN cycles): issue in_addr=i, w_addr=j*N_IN+i, w_rd=1; i increments each cycle. From the second SCAN cycle on, consume the previous cycle's in_bit/w_data: if in_bit=1, drive nrn_func=0, nrn_vmem=acc, nrn_weight=w_data and capture acc<=nrn_result. After issuing i=N_IN-1, go to DRAIN.
- DRAIN (1 cycle): consume the last issued pair with the same rule; w_rd=0.
- FIRE (1 cycle): nrn_func=0, nrn_vmem=acc, nrn_weight=0. If nrn_spike, set vmem[j]<=0 and go to EMIT. Else set vmem[j]<=acc, then go to LEAK with j+1, or to DONE if j=N_OUT-1.
- EMIT: spk_valid=1, spk_id=j, held stable until the cycle with spk_ready=1. Then go to LEAK with j+1, or to DONE if j=N_OUT-1.
- DONE (1 cycle): done=1, then IDLE.
- Outside their consuming states, nrn_* operands are 0.
- Saturation and leak arithmetic belong to the neuron. The scheduler only stores 8-bit results, unsigned, with no wrap handling.
- start/clear while busy: ignored, not queued.

## Timing
- Reset (async assert, sync deassert by source): FSM=IDLE, all vmem=0, acc=0, i=j=0. All outputs 0: busy, done, w_rd, spk_valid, spk_id, in_addr, w_addr, nrn_*.
- start sampled at edge k gives busy=1 from k+1.
- Cycles per neuron with no back-pressure: LEAK 1 + SCAN N_IN + DRAIN 1 + FIRE 1 = N_IN+3. Add 1 + stall cycles if EMIT is entered.
- done asserts N_OUT*(N_IN+3) + (EMIT cycles) cycles after busy rises; busy drops the cycle after done.
- Read latency of the bitmap and SRAM port is exactly 1 cycle; there is no stall inside SCAN.
- Reset mid-timestep aborts immediately. No done pulse is issued and a pending spk_valid drops.

## Test plan
- Reset then idle: all outputs 0, dbg_vmem=0 for all ids; 10 idle cycles with start=0 keep busy=0.
- Bench neuron stub: integrate = saturating add, spike = v>=100, leak = v-(v>>2). All weights 10, only in_bit[5] and in_bit[7] set, one start. Required: every vmem=20, no spk_valid, done exactly 10*199=1990 cycles after busy rises.
- Same setup with in_bit 0..11 set (sum 120): every neuron fires. spk_id sequence is 0..9. Every vmem=0 after done.
- Same as the previous scenario with spk_ready held low for 5 cycles on the first event: spk_valid/spk_id=0 held stable. done is delayed by exactly 5 cycles relative to an unstalled run.
- Two timesteps with weight 40 on in 3 only: vmem=40 after the first timestep and 30+40=70 after the second. The clear pulse in IDLE returns all to 0. A start pulse at the same time as clear runs a timestep with no clear.
- rst_n low during SCAN of neuron 4: the next cycle shows busy=0, w_rd=0, and all vmem=0. A fresh start then completes normally.
